min_sec_counter: RTL and testbench

MIN_SEC_COUNTER -- requirements
Module: min_sec_counter

---
 rtl/clock_pkg.sv | 7 +
 rtl/bcd_mod60.sv | 37 +++
 rtl/min_sec_counter.sv | 57 +++++
 tb/tb_min_sec_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD digit type, digit limits and default tick rate for the clock blocks.
package clock_pkg;
    typedef logic [3:0] bcd_t;
    localparam bcd_t UNITS_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;
    localparam int DEFAULT_CLK_HZ = 50_000_000;
endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60: two-digit BCD mod-60 counter advancing by 0, 1 (inc) or 2 (add2) per cycle.
module bcd_mod60
    import clock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic add2,
    input  logic clr,
    output bcd_t lo,
    output bcd_t hi,
    output logic carry_out
);
    logic [1:0] step;
    logic [4:0] u_sum;
    logic u_wrap;
    bcd_t lo_next;
    bcd_t hi_next;
    always_comb begin
        step = add2 ? 2'd2 : {1'b0, inc};
        u_sum = {1'b0, lo} + {3'b0, step};
        u_wrap = u_sum > {1'b0, UNITS_MAX};
        lo_next = u_wrap ? u_sum[3:0] - 4'd10 : u_sum[3:0];
        hi_next = u_wrap ? (hi == TENS_MAX ? '0 : hi + 4'd1) : hi;
        // a clear discards this cycle's advance, so it must not leak a carry
        carry_out = !clr && u_wrap && hi == TENS_MAX;
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= lo_next;
            hi <= hi_next;
        end
    end
endmodule

// File: rtl/min_sec_counter.sv
// min_sec_counter: prescaled 1 Hz minutes:seconds BCD clock with time-set inputs and hour pulse.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic inc_min,
    input  logic clr_sec,
    output bcd_t sec_1,
    output bcd_t sec_2,
    output bcd_t min_1,
    output bcd_t min_2,
    output logic tick_1hz,
    output logic hour_inc
);
    localparam int PW = $clog2(CLK_HZ);
    logic [PW-1:0] presc;
    logic tick;
    logic sec_carry;
    logic min_carry;
    assign tick = run && presc == PW'(CLK_HZ - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tick_1hz <= 1'b0;
            hour_inc <= 1'b0;
        end else begin
            presc <= (clr_sec || tick) ? '0 : presc + PW'(run);
            tick_1hz <= tick && !clr_sec;
            // only a seconds rollover counts as an hour; manual minute bumps never do
            hour_inc <= min_carry && sec_carry;
        end
    end
    bcd_mod60 u_sec (
        .clk(clk),
        .rst(rst),
        .inc(tick),
        .add2(1'b0),
        .clr(clr_sec),
        .lo(sec_1),
        .hi(sec_2),
        .carry_out(sec_carry)
    );
    bcd_mod60 u_min (
        .clk(clk),
        .rst(rst),
        .inc(sec_carry ^ inc_min),
        .add2(sec_carry & inc_min),
        .clr(1'b0),
        .lo(min_1),
        .hi(min_2),
        .carry_out(min_carry)
    );
endmodule

// File: tb/tb_min_sec_counter.sv
// tb_min_sec_counter: directed scenarios plus random traffic against a total-seconds reference model.
module tb_min_sec_counter;
    localparam int CLK = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic inc_min = 1'b0;
    logic clr_sec = 1'b0;
    logic [3:0] sec_1, sec_2, min_1, min_2;
    logic tick_1hz, hour_inc;
    int vectors = 0;
    int miscompares = 0;
    int secs_m = 0;
    int p_m = 0;
    logic tick_m = 1'b0;
    logic hour_m = 1'b0;

    min_sec_counter #(.CLK_HZ(CLK)) dut (
        .clk(clk), .rst(rst), .run(run), .inc_min(inc_min), .clr_sec(clr_sec),
        .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
        .tick_1hz(tick_1hz), .hour_inc(hour_inc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic ru, input logic im, input logic cs);
        int s, m, msum;
        logic t, c;
        rst = r;
        run = ru;
        inc_min = im;
        clr_sec = cs;
        @(posedge clk);
        if (r) begin
            secs_m = 0;
            p_m = 0;
            tick_m = 1'b0;
            hour_m = 1'b0;
        end else begin
            s = secs_m % 60;
            m = secs_m / 60;
            t = ru && p_m == CLK - 1;
            c = t && !cs && s == 59;
            p_m = cs ? 0 : ru ? (p_m + 1) % CLK : p_m;
            s = cs ? 0 : t ? (s + 1) % 60 : s;
            msum = m + int'(c) + int'(im);
            hour_m = c && msum >= 60;
            tick_m = t && !cs;
            secs_m = (msum % 60) * 60 + s;
        end
        #1;
        chk("sec_1", sec_1, 4'(secs_m % 10));
        chk("sec_2", sec_2, 4'((secs_m % 60) / 10));
        chk("min_1", min_1, 4'((secs_m / 60) % 10));
        chk("min_2", min_2, 4'(secs_m / 600));
        chk("tick_1hz", {3'b0, tick_1hz}, {3'b0, tick_m});
        chk("hour_inc", {3'b0, hour_inc}, {3'b0, hour_m});
    endtask

    task automatic run_n(input int n, input logic ru, input logic im, input logic cs);
        repeat (n) cyc(1'b0, ru, im, cs);
    endtask

    task automatic to_5959();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_n(59, 1'b0, 1'b1, 1'b0);
        run_n(59 * CLK, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // scenario 1: first two seconds after reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_sec_1", sec_1, 4'd0);
        chk("rst_hour", {3'b0, hour_inc}, 4'd0);
        run_n(3, 1'b1, 1'b0, 1'b0);
        chk("s1_no_early_tick", {3'b0, tick_1hz}, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s1_tick1", {3'b0, tick_1hz}, 4'd1);
        chk("s1_sec01", sec_1, 4'd1);
        run_n(3, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s1_tick2", {3'b0, tick_1hz}, 4'd1);
        chk("s1_sec02", sec_1, 4'd2);
        // scenario 2: 00:59 -> 01:00 without hour_inc
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_n(60 * CLK, 1'b1, 1'b0, 1'b0);
        chk("s2_min_1", min_1, 4'd1);
        chk("s2_sec_2", sec_2, 4'd0);
        chk("s2_hour", {3'b0, hour_inc}, 4'd0);
        // scenario 3: 59:59 -> 00:00 with hour_inc
        run_n(58, 1'b0, 1'b1, 1'b0);
        run_n(59 * CLK, 1'b1, 1'b0, 1'b0);
        chk("s3_pre_min_2", min_2, 4'd5);
        chk("s3_pre_sec_1", sec_1, 4'd9);
        run_n(CLK, 1'b1, 1'b0, 1'b0);
        chk("s3_min_2", min_2, 4'd0);
        chk("s3_hour", {3'b0, hour_inc}, 4'd1);
        chk("s3_tick", {3'b0, tick_1hz}, 4'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s3_hour_once", {3'b0, hour_inc}, 4'd0);
        // scenario 4: inc_min in the rollover tick cycle
        to_5959();
        run_n(CLK - 1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("s4_min_1", min_1, 4'd1);
        chk("s4_min_2", min_2, 4'd0);
        chk("s4_sec_1", sec_1, 4'd0);
        chk("s4_hour", {3'b0, hour_inc}, 4'd1);
        // scenario 4b: clr_sec in the rollover tick cycle
        to_5959();
        run_n(CLK - 1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("s4b_min_2", min_2, 4'd5);
        chk("s4b_min_1", min_1, 4'd9);
        chk("s4b_sec_2", sec_2, 4'd0);
        chk("s4b_tick", {3'b0, tick_1hz}, 4'd0);
        chk("s4b_hour", {3'b0, hour_inc}, 4'd0);
        // scenario 5: frozen at 12:34, three manual minute bumps, prescaler held mid-count
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_n(12, 1'b0, 1'b1, 1'b0);
        run_n(34 * CLK + 2, 1'b1, 1'b0, 1'b0);
        run_n(20, 1'b0, 1'b0, 1'b0);
        run_n(3, 1'b0, 1'b1, 1'b0);
        chk("s5_min_2", min_2, 4'd1);
        chk("s5_min_1", min_1, 4'd5);
        chk("s5_sec_2", sec_2, 4'd3);
        chk("s5_sec_1", sec_1, 4'd4);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s5_no_tick", {3'b0, tick_1hz}, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s5_tick", {3'b0, tick_1hz}, 4'd1);
        chk("s5_sec_1", sec_1, 4'd5);
        // scenario 6: reset on the hour_inc cycle
        to_5959();
        run_n(CLK, 1'b1, 1'b0, 1'b0);
        chk("s6_hour", {3'b0, hour_inc}, 4'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("s6_rst_hour", {3'b0, hour_inc}, 4'd0);
        chk("s6_rst_min_1", min_1, 4'd0);
        run_n(CLK - 1, 1'b1, 1'b0, 1'b0);
        chk("s6_no_early_tick", {3'b0, tick_1hz}, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s6_tick", {3'b0, tick_1hz}, 4'd1);
        chk("s6_sec_1", sec_1, 4'd1);
        run_n(8, 1'b1, 1'b0, 1'b0);
        // random traffic, each burst starting near an hour rollover
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            run_n(59, 1'b0, 1'b1, 1'b0);
            run_n(55 * CLK, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 600; i++)
                cyc($urandom_range(0, 999) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 399) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
